// File: rtl/uart_tx_source_arbiter.sv
// uart_tx_source_arbiter
//   Frame-safe N-way multiplexer that drives one UART TXD pin from NUM_SRC
//   same-clock TX lines. When the select changes, the old source is allowed
//   to finish its frame (DRAIN) before the switch happens. The new source is
//   then masked to mark (BLANK) until it has shown a full idle guard, so a
//   partial frame from the new source never reaches the pin.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   tx_in        TX line of each source (idle = 1)
//   sel_req      requested source; values >= NUM_SRC are ignored
//   sel_force    one-cycle pulse that skips the drain wait while in DRAIN
//   TXD          registered pin output
//   sel_active   source that currently owns the line
//   switch_busy  high whenever a switch is in progress (state != PASS)
module uart_tx_source_arbiter #(
    parameter int NUM_SRC     = 2,
    parameter int BAUD_PERIOD = 833,
    parameter int IDLE_BITS   = 11,
    parameter int SEL_W       = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] tx_in,
    input  logic [SEL_W-1:0]   sel_req,
    input  logic               sel_force,
    output logic               TXD,
    output logic [SEL_W-1:0]   sel_active,
    output logic               switch_busy
);

    localparam int G     = IDLE_BITS * BAUD_PERIOD;
    localparam int CNT_W = $clog2(G + 1);
    localparam logic [CNT_W-1:0] G_C = CNT_W'(G);

    typedef enum logic [1:0] {PASS, DRAIN, BLANK} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               txd_q, txd_d;

    logic mon;
    logic req_valid;
    logic req_new;

    assign mon       = tx_in[sel_q];
    assign req_valid = ({1'b0, sel_req} < (SEL_W+1)'(NUM_SRC));
    assign req_new   = req_valid && (sel_req != sel_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        // Idle-run counter on the monitored line: any 0 restarts the guard.
        if (!mon)
            cnt_d = '0;
        else if (cnt_q == G_C)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            PASS: begin
                cnt_d = '0;
                if (req_new) begin
                    tgt_d   = sel_req;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (req_valid && sel_req == sel_q) begin
                    // Request withdrawn: keep the current owner.
                    state_d = PASS;
                    cnt_d   = '0;
                end else begin
                    // Retarget keeps the count: the monitored line is unchanged.
                    if (req_new)
                        tgt_d = sel_req;
                    if (sel_force || cnt_q == G_C) begin
                        sel_d   = tgt_d;
                        state_d = BLANK;
                        cnt_d   = '0;
                    end
                end
            end
            BLANK: begin
                if (req_new) begin
                    // Line is already held at mark, so hop directly.
                    sel_d = sel_req;
                    tgt_d = sel_req;
                    cnt_d = '0;
                end else if (cnt_q == G_C) begin
                    state_d = PASS;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PASS;
                cnt_d   = '0;
            end
        endcase

        // Mark is forced from the cycle the switch happens until PASS resumes.
        txd_d = (state_q == BLANK || state_d == BLANK) ? 1'b1 : mon;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PASS;
            sel_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
        end
    end

    assign TXD         = txd_q;
    assign sel_active  = sel_q;
    assign switch_busy = (state_q != PASS);

endmodule

// File: tb/tb_uart_tx_source_arbiter.sv
// Testbench for uart_tx_source_arbiter with NUM_SRC=3, BAUD_PERIOD=4,
// IDLE_BITS=2 (guard G = 8 cycles, one UART frame = 40 cycles).
// Cycle numbering in the sequences: cycle 0 is the cycle in which the
// stimulus is applied; after each tick the registered outputs of the next
// cycle are sampled 1 ns after the rising edge.
module tb_uart_tx_source_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] tx_in;
    logic [1:0] sel_req;
    logic       sel_force;
    logic       TXD;
    logic [1:0] sel_active;
    logic       switch_busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_source_arbiter #(
        .NUM_SRC(3), .BAUD_PERIOD(4), .IDLE_BITS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tx_in(tx_in), .sel_req(sel_req),
        .sel_force(sel_force), .TXD(TXD), .sel_active(sel_active),
        .switch_busy(switch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tx;
        logic [1:0] req;
        logic       frc;
        logic       txd;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Line level of an 8N1 frame, t cycles after the start bit begins.
    function automatic logic frame_bit(input logic [7:0] b, input int t);
        if (t < 0)  return 1'b1;
        if (t < 4)  return 1'b0;
        if (t < 36) return b[(t-4)/4];
        return 1'b1;
    endfunction

    // Switch with all lines idle; bounded wait on switch_busy falling.
    task automatic do_switch(input logic [1:0] n);
        bit done = 0;
        sel_req = n;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i > 0 && !switch_busy) begin
                done = 1;
                break;
            end
        end
        chk("switch_done", {31'd0, done}, 32'd1);
        chk("switch_sel", {30'd0, sel_active}, {30'd0, n});
    endtask

    initial begin
        logic [7:0] b;
        reset_n   = 1'b0;
        tx_in     = 3'b111;
        sel_req   = 2'd0;
        sel_force = 1'b0;
        #12;
        chk("rst_txd",  {31'd0, TXD}, 32'd1);
        chk("rst_sel",  {30'd0, sel_active}, 32'd0);
        chk("rst_busy", {31'd0, switch_busy}, 32'd0);
        #3 reset_n = 1'b1;
        tick();

        // ---- table: pass-through, illegal select, force ignored in PASS
        vecs[0] = '{3'b111, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[1] = '{3'b110, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[2] = '{3'b111, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[3] = '{3'b010, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[4] = '{3'b011, 2'd3, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[5] = '{3'b000, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[6] = '{3'b101, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[7] = '{3'b111, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tx_in = vecs[i].tx; sel_req = vecs[i].req; sel_force = vecs[i].frc;
            tick();
            chk($sformatf("vec%0d_txd", i),  {31'd0, TXD}, {31'd0, vecs[i].txd});
            chk($sformatf("vec%0d_sel", i),  {30'd0, sel_active}, {30'd0, vecs[i].sel});
            chk($sformatf("vec%0d_busy", i), {31'd0, switch_busy}, {31'd0, vecs[i].busy});
        end
        sel_force = 1'b0; sel_req = 2'd0; tx_in = 3'b111;
        tick();

        // ---- 1: async reset mid-DRAIN, then 0x55 pass-through
        tx_in[0] = 1'b0; sel_req = 2'd1;
        tick(); tick(); tick();
        chk("t1_drain_busy", {31'd0, switch_busy}, 32'd1);
        chk("t1_drain_txd",  {31'd0, TXD}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_arst_txd",  {31'd0, TXD}, 32'd1);
        chk("t1_arst_sel",  {30'd0, sel_active}, 32'd0);
        chk("t1_arst_busy", {31'd0, switch_busy}, 32'd0);
        sel_req = 2'd0; tx_in = 3'b111;
        #1 reset_n = 1'b1;
        tick();
        b = 8'h55;
        tx_in[0] = frame_bit(b, 0);
        for (int c = 1; c <= 41; c++) begin
            tick();
            chk("t1_55_txd", {31'd0, TXD}, {31'd0, frame_bit(b, c-1)});
            tx_in[0] = frame_bit(b, c);
        end
        tx_in = 3'b111;
        tick();

        // ---- 2: clean switch 0 -> 1, both idle
        sel_req = 2'd1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("t2_busy", {31'd0, switch_busy}, {31'd0, (c <= 18)});
            chk("t2_sel",  {30'd0, sel_active}, (c >= 10) ? 32'd1 : 32'd0);
            chk("t2_txd",  {31'd0, TXD}, (c == 20) ? 32'd0 : 32'd1);
            if (c == 19) tx_in[1] = 1'b0;
        end
        tx_in = 3'b111;
        tick(); tick();

        // ---- 3: frame protection, 0 -> 2 requested mid 0xA3.
        // 0xA3 has data bit 7 = 1, so the final high run starts at t=32;
        // the guard completes at cycle 40 and the switch lands in cycle 41,
        // after the stop bit has been delivered.
        do_switch(2'd0);
        b = 8'hA3;
        tx_in[0] = frame_bit(b, 0);
        for (int c = 1; c <= 50; c++) begin
            tick();
            chk("t3_txd",  {31'd0, TXD}, (c >= 41) ? 32'd1 : {31'd0, frame_bit(b, c-1)});
            chk("t3_sel",  {30'd0, sel_active}, (c >= 41) ? 32'd2 : 32'd0);
            chk("t3_busy", {31'd0, switch_busy}, {31'd0, (c >= 9 && c <= 49)});
            tx_in[0] = frame_bit(b, c);
            if (c == 8) sel_req = 2'd2;
        end
        tx_in = 3'b111;
        tick();

        // ---- 4: partial-frame blanking, src1 frame 0x55 starts at cycle 2.
        // Last low bit ends at cycle 37; 8 high cycles -> PASS at cycle 47.
        b = 8'h55;
        sel_req = 2'd1;
        for (int c = 1; c <= 48; c++) begin
            tick();
            chk("t4_txd",  {31'd0, TXD}, (c == 48) ? 32'd0 : 32'd1);
            chk("t4_sel",  {30'd0, sel_active}, (c >= 10) ? 32'd1 : 32'd2);
            chk("t4_busy", {31'd0, switch_busy}, {31'd0, (c <= 46)});
            if (c == 47)     tx_in[1] = 1'b0;
            else if (c >= 2) tx_in[1] = frame_bit(b, c-2);
        end
        tx_in = 3'b111;
        tick();

        // ---- 5a: cancel during DRAIN while src0 sends 0x55
        do_switch(2'd0);
        sel_req = 2'd1;
        tx_in[0] = frame_bit(b, 0);
        for (int c = 1; c <= 41; c++) begin
            tick();
            chk("t5a_txd",  {31'd0, TXD}, {31'd0, frame_bit(b, c-1)});
            chk("t5a_sel",  {30'd0, sel_active}, 32'd0);
            chk("t5a_busy", {31'd0, switch_busy}, {31'd0, (c <= 4)});
            tx_in[0] = frame_bit(b, c);
            if (c == 4) sel_req = 2'd0;
        end
        tx_in = 3'b111;
        tick();

        // ---- 5b: retarget during BLANK, 0 -> 1 then 2 at cycle 13
        sel_req = 2'd1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk("t5b_txd",  {31'd0, TXD}, 32'd1);
            chk("t5b_sel",  {30'd0, sel_active}, (c < 10) ? 32'd0 : ((c < 14) ? 32'd1 : 32'd2));
            chk("t5b_busy", {31'd0, switch_busy}, {31'd0, (c <= 22)});
            if (c == 13) sel_req = 2'd2;
        end

        // ---- 6: illegal select, then force in DRAIN during src0 data
        sel_req = 2'd3;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("t6_ill_busy", {31'd0, switch_busy}, 32'd0);
            chk("t6_ill_sel",  {30'd0, sel_active}, 32'd2);
        end
        do_switch(2'd0);
        b = 8'h00;
        sel_req = 2'd1;
        tx_in[0] = frame_bit(b, 0);
        for (int c = 1; c <= 17; c++) begin
            tick();
            chk("t6_txd",  {31'd0, TXD}, (c >= 7) ? 32'd1 : 32'd0);
            chk("t6_sel",  {30'd0, sel_active}, (c >= 7) ? 32'd2 : 32'd0);
            chk("t6_busy", {31'd0, switch_busy}, {31'd0, (c <= 15)});
            tx_in[0] = frame_bit(b, c);
            sel_force = (c == 6);
            if (c == 6) sel_req = 2'd2;
        end
        tx_in = 3'b111;
        sel_force = 1'b1;
        tick();
        sel_force = 1'b0;
        chk("t6_pass_force_busy", {31'd0, switch_busy}, 32'd0);
        chk("t6_pass_force_sel",  {30'd0, sel_active}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
